md_unit: RTL and testbench

Multi-cycle multiply/divide unit for the EX stage, alongside the ALU. It takes the same A and B operands the ALU receives and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO against private HI/LO registers. It also exports a busy/stall indication so hazard control can freeze the pipeline while an operation is in flight. MFHI/MFLO read the HI and LO outputs directly.

---
 rtl/md_unit.sv | 172 +++++++++++++++++
 tb/tb_md_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with private HI/LO registers.
// Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply/divide results
// are computed at the accept edge, held for a fixed number of busy cycles,
// then committed to HI/LO so hazard control sees a fixed latency.
//
// Ports:
//   clk    - clock, all state updates on rising edge
//   reset  - synchronous active-high reset, clears all state
//   start  - request strobe for one EX cycle
//   mdop   - operation select (001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//            101 MTHI, 110 MTLO, others none)
//   A, B   - rs / rt operands
//   busy   - registered, high while a mult/div is in flight
//   stall  - combinational pipeline freeze request
//   HI, LO - registered HI/LO
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  mdop,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 4;

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [W-1:0]    res_hi, res_hi_n;
   logic [W-1:0]    res_lo, res_lo_n;
   logic            dz, dz_n;
   logic            busy_n;
   logic [W-1:0]    hi_n, lo_n;

   logic            is_md;
   logic            is_sdiv;
   logic [W-1:0]    a_mag, b_mag;
   logic [W-1:0]    dvd, dvs;
   logic [W-1:0]    uq, ur;
   logic [W-1:0]    quo, rem;
   logic [2*W-1:0]  prod_s, prod_u;

   // Pipeline freeze: a mult/div being presented, or one already in flight.
   assign is_md = (mdop == OP_MULT) || (mdop == OP_MULTU) ||
                  (mdop == OP_DIV)  || (mdop == OP_DIVU);
   assign stall = (start && is_md) || busy;

   // Arithmetic datapath. Signed divide runs on magnitudes so the
   // 0x80000000 / -1 case falls out naturally as 0x80000000 rem 0.
   always_comb begin
      is_sdiv = (mdop == OP_DIV);
      a_mag   = A[W-1] ? (~A + W'(1)) : A;
      b_mag   = B[W-1] ? (~B + W'(1)) : B;
      dvd     = is_sdiv ? a_mag : A;
      dvs     = is_sdiv ? b_mag : B;
      // Divide-by-zero result is discarded; substitute 1 to keep it defined.
      if (B == '0) begin
         dvs = W'(1);
      end
      uq  = dvd / dvs;
      ur  = dvd % dvs;
      quo = (is_sdiv && (A[W-1] ^ B[W-1])) ? (~uq + W'(1)) : uq;
      rem = (is_sdiv && A[W-1]) ? (~ur + W'(1)) : ur;
      // Low 64 bits of a 64x64 product of sign-extended operands is the
      // exact signed 32x32 product.
      prod_s = {{W{A[W-1]}}, A} * {{W{B[W-1]}}, B};
      prod_u = {{W{1'b0}}, A} * {{W{1'b0}}, B};
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      res_hi_n = res_hi;
      res_lo_n = res_lo;
      dz_n     = dz;
      busy_n   = busy;
      hi_n     = HI;
      lo_n     = LO;
      case (state)
         S_IDLE: begin
            if (start) begin
               case (mdop)
                  OP_MULT: begin
                     {res_hi_n, res_lo_n} = prod_s;
                     dz_n    = 1'b0;
                     cnt_n   = MULT_LOAD;
                     busy_n  = 1'b1;
                     state_n = S_RUN;
                  end
                  OP_MULTU: begin
                     {res_hi_n, res_lo_n} = prod_u;
                     dz_n    = 1'b0;
                     cnt_n   = MULT_LOAD;
                     busy_n  = 1'b1;
                     state_n = S_RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     res_hi_n = rem;
                     res_lo_n = quo;
                     dz_n     = (B == '0);
                     cnt_n    = DIV_LOAD;
                     busy_n   = 1'b1;
                     state_n  = S_RUN;
                  end
                  OP_MTHI: hi_n = A;
                  OP_MTLO: lo_n = A;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            // Requests arriving here are ignored; upstream holds via stall.
            if (cnt != '0) begin
               cnt_n = cnt - CW'(1);
            end else begin
               if (!dz) begin
                  hi_n = res_hi;
                  lo_n = res_lo;
               end
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         res_hi <= '0;
         res_lo <= '0;
         dz     <= 1'b0;
         busy   <= 1'b0;
         HI     <= '0;
         LO     <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         res_hi <= res_hi_n;
         res_lo <= res_lo_n;
         dz     <= dz_n;
         busy   <= busy_n;
         HI     <= hi_n;
         LO     <= lo_n;
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit with a reference
// model feeding an expected-result queue.
module tb_md_unit;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  mdop;
   logic [31:0] a, b;
   logic        busy, stall;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } exp_t;

   exp_t        scb[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .mdop(mdop),
      .A(a), .B(b), .busy(busy), .stall(stall), .HI(hi), .LO(lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: computes expected HI/LO with 64-bit arithmetic.
   task automatic model_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      exp_t   e;
      longint sx, sy, q, r;
      logic [63:0] ux, uy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      e.hi = m_hi;
      e.lo = m_lo;
      e.n  = int'(DC);
      case (op)
         3'b001: begin p = 64'(sx * sy); e.hi = p[63:32]; e.lo = p[31:0]; e.n = int'(MC); end
         3'b010: begin p = ux * uy;      e.hi = p[63:32]; e.lo = p[31:0]; e.n = int'(MC); end
         3'b011: if (y != 0) begin q = sx / sy; r = sx % sy; e.lo = 32'(q); e.hi = 32'(r); end
         3'b100: if (y != 0) begin e.lo = 32'(ux / uy); e.hi = 32'(ux % uy); end
         default: ;
      endcase
      m_hi = e.hi;
      m_lo = e.lo;
      scb.push_back(e);
   endtask

   // Present a mult/div for one cycle; returns just after the accept edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; mdop = op; a = x; b = y;
      #1;
      check("stall_accept", 32'(stall), 32'd1);
      model_op(op, x, y);
      tick();
      start = 1'b0; mdop = 3'b000;
      a = $urandom; b = $urandom;
   endtask

   task automatic issue_mt(input logic [2:0] op, input logic [31:0] x);
      start = 1'b1; mdop = op; a = x;
      #1;
      check("mt_stall", 32'(stall), 32'd0);
      if (op == 3'b101) m_hi = x; else m_lo = x;
      tick();
      start = 1'b0; mdop = 3'b000;
      check("mt_busy", 32'(busy), 32'd0);
      check("mt_hi", hi, m_hi);
      check("mt_lo", lo, m_lo);
   endtask

   // Wait out the busy window and compare against the queue head.
   // mode 1: pulse MULT then MTLO early in RUN; mode 2: MULT in last busy cycle.
   task automatic wait_done(input int mode);
      exp_t        e;
      int          cyc, nst;
      logic [31:0] h0, l0;
      e   = scb.pop_front();
      h0  = hi;
      l0  = lo;
      cyc = 0;
      nst = 1;
      while (busy && cyc < 40) begin
         if (stall) nst++;
         check("hold_hi", hi, h0);
         check("hold_lo", lo, l0);
         start = 1'b0; mdop = 3'b000;
         if (mode == 1 && cyc == 0) begin start = 1'b1; mdop = 3'b001; a = 32'd9; b = 32'd9; end
         if (mode == 1 && cyc == 1) begin start = 1'b1; mdop = 3'b110; a = 32'h5555_5555; end
         if (mode == 2 && cyc == e.n - 1) begin start = 1'b1; mdop = 3'b001; a = 32'd3; b = 32'd3; end
         tick();
         cyc++;
      end
      start = 1'b0; mdop = 3'b000;
      check("busy_cycles", 32'(cyc), 32'(e.n));
      check("stall_cycles", 32'(nst), 32'(e.n + 1));
      check("res_hi", hi, e.hi);
      check("res_lo", lo, e.lo);
      #1;
      check("idle_after", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; mdop = 3'b000; a = '0; b = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);

      // Signed multiply, then back-to-back unsigned multiply.
      issue(3'b001, 32'hFFFF_FFFE, 32'd3);
      wait_done(0);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFA);
      issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(0);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);

      // Signed divide and the overflow case.
      issue(3'b011, 32'hFFFF_FFF9, 32'd2);
      wait_done(0);
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);
      issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(0);
      check("divov_lo", lo, 32'h8000_0000);
      check("divov_hi", hi, 32'h0000_0000);

      // Preload, then divide by zero leaves HI/LO untouched.
      issue_mt(3'b101, 32'h0000_1234);
      issue_mt(3'b110, 32'h0000_5678);
      issue(3'b100, 32'd77, 32'd0);
      wait_done(0);
      check("dz_hi", hi, 32'h0000_1234);
      check("dz_lo", lo, 32'h0000_5678);

      // Starts during RUN are ignored; MULT right after completion accepted.
      issue(3'b011, 32'd100, 32'd7);
      wait_done(1);
      check("ign_hi", hi, 32'd2);
      check("ign_lo", lo, 32'd14);
      issue(3'b001, 32'd6, 32'd7);
      check("b2b_busy", 32'(busy), 32'd1);
      wait_done(0);
      check("b2b_lo", lo, 32'd42);

      // Start coinciding with completion is ignored.
      issue(3'b010, 32'h0001_0000, 32'h0001_0000);
      wait_done(2);

      // none / reserved opcodes do nothing.
      start = 1'b1; mdop = 3'b000; a = 32'hDEAD_BEEF;
      #1;
      check("none_stall", 32'(stall), 32'd0);
      tick();
      mdop = 3'b111;
      #1;
      check("rsv_stall", 32'(stall), 32'd0);
      tick();
      start = 1'b0; mdop = 3'b000;
      check("rsv_busy", 32'(busy), 32'd0);
      check("rsv_hi", hi, m_hi);
      check("rsv_lo", lo, m_lo);

      // Randomised operations against the model.
      for (int i = 0; i < 8; i++) begin
         logic [2:0]  op;
         logic [31:0] x, y;
         op = 3'(1 + $urandom_range(3));
         x  = $urandom;
         y  = (i == 5) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(100)) : $urandom);
         issue(op, x, y);
         wait_done(0);
      end

      // Reset at busy cycle 3 aborts the MULT.
      issue_mt(3'b101, 32'hAAAA_AAAA);
      issue_mt(3'b110, 32'hAAAA_AAAA);
      issue(3'b001, 32'd3, 32'd4);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      void'(scb.pop_front());
      m_hi = '0; m_lo = '0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      repeat (8) tick();
      check("late_busy", 32'(busy), 32'd0);
      check("late_hi", hi, 32'd0);
      check("late_lo", lo, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
